// File: rtl/rr_arbiter_32.sv
// rtl/rr_arbiter_32.sv - round-robin arbiter with registered one-hot grant and hold-time limit
// Optional grantee lock is enabled by defining RR_ARB_LOCK_EN.
module rr_arbiter_32 #(
  parameter int N = 32,
  localparam int IDX_W = $clog2(N),
  parameter int MAX_HOLD = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N-1:0]     req_i,
  input  logic             done_i,
`ifdef RR_ARB_LOCK_EN
  input  logic             lock_i,
`endif
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_valid_o,
  output logic             timeout_o
);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  localparam int HC_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt, winner, idx_nxt;
  logic [HC_W-1:0]  hold_cnt, hold_nxt;
  logic [N-1:0]     masked, gnt_nxt;
  logic             valid_nxt, timeout_nxt;
  logic             lock, rel_a, rel_b, rel_c, release_now;

`ifdef RR_ARB_LOCK_EN
  assign lock = lock_i;
`else
  assign lock = 1'b0;
`endif

  // Rotating-mask priority encode: lowest request at/above ptr, else lowest overall.
  always_comb begin
    masked = '0;
    for (int k = 0; k < N; k++) masked[k] = req_i[k] && (k >= int'(ptr));
    winner = '0;
    for (int k = N - 1; k >= 0; k--) if (req_i[k]) winner = IDX_W'(k);
    for (int k = N - 1; k >= 0; k--) if (masked[k]) winner = IDX_W'(k);
  end

  assign rel_a       = done_i;
  assign rel_b       = !req_i[gnt_idx_o];
  assign rel_c       = (MAX_HOLD != 0) && !lock && (hold_cnt == HOLD_LAST);
  assign release_now = rel_a || rel_b || rel_c;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      ptr         <= '0;
      hold_cnt    <= '0;
      gnt_o       <= '0;
      gnt_idx_o   <= '0;
      gnt_valid_o <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      hold_cnt    <= hold_nxt;
      gnt_o       <= gnt_nxt;
      gnt_idx_o   <= idx_nxt;
      gnt_valid_o <= valid_nxt;
      timeout_o   <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, RELEASE: state_nxt = (|req_i) ? GRANT : IDLE;
      GRANT:         if (release_now) state_nxt = RELEASE;
      default:       state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ptr_nxt     = ptr;
    hold_nxt    = hold_cnt;
    gnt_nxt     = gnt_o;
    idx_nxt     = gnt_idx_o;
    valid_nxt   = gnt_valid_o;
    timeout_nxt = 1'b0;
    case (state)
      IDLE, RELEASE: begin
        if (|req_i) begin
          gnt_nxt   = {{(N-1){1'b0}}, 1'b1} << winner;
          idx_nxt   = winner;
          valid_nxt = 1'b1;
          hold_nxt  = '0;
        end else begin
          gnt_nxt   = '0;
          valid_nxt = 1'b0;
        end
      end
      GRANT: begin
        if (release_now) begin
          gnt_nxt   = '0;
          valid_nxt = 1'b0;
          ptr_nxt   = (gnt_idx_o == IDX_W'(N - 1)) ? '0 : gnt_idx_o + 1'b1;
`ifdef RR_ARB_LOCK_EN
          // A locked grantee finishing keeps priority; a dropped request never does.
          if (rel_a && lock && !rel_b) ptr_nxt = gnt_idx_o;
`endif
          timeout_nxt = rel_c && !rel_a && !rel_b;
        end else if (!lock) begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      default: begin
        gnt_nxt   = '0;
        valid_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rr_arbiter_32.sv
// tb/tb_rr_arbiter_32.sv - directed scoreboard bench for rr_arbiter_32
module tb_rr_arbiter_32;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic [31:0] req_i = '0;
  logic        done_i = 1'b0;
`ifdef RR_ARB_LOCK_EN
  logic        lock_i = 1'b0;
`endif
  logic [31:0] gnt_o;
  logic [4:0]  gnt_idx_o;
  logic        gnt_valid_o;
  logic        timeout_o;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] gnt;
    logic [4:0]  idx;
    logic        valid;
    logic        to;
  } exp_t;

  exp_t sb[$];

  rr_arbiter_32 dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (req_i),
    .done_i      (done_i),
`ifdef RR_ARB_LOCK_EN
    .lock_i      (lock_i),
`endif
    .gnt_o       (gnt_o),
    .gnt_idx_o   (gnt_idx_o),
    .gnt_valid_o (gnt_valid_o),
    .timeout_o   (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (rst_ni) begin
      checks++;
      assert ($onehot0(gnt_o) && (gnt_valid_o === (|gnt_o)))
      else begin
        failures++;
        $error("FAIL onehot observed gnt=%h valid=%b expected one-hot-or-zero with matching valid", gnt_o, gnt_valid_o);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_out();
    exp_t e;
    checks++;
    assert (sb.size() > 0)
    else begin
      failures++;
      $error("FAIL scoreboard observed=empty expected=entry");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks += 4;
      assert (gnt_o === e.gnt)
      else begin failures++; $error("FAIL gnt observed=%h expected=%h", gnt_o, e.gnt); end
      assert (gnt_idx_o === e.idx)
      else begin failures++; $error("FAIL gnt_idx observed=%0d expected=%0d", gnt_idx_o, e.idx); end
      assert (gnt_valid_o === e.valid)
      else begin failures++; $error("FAIL gnt_valid observed=%b expected=%b", gnt_valid_o, e.valid); end
      assert (timeout_o === e.to)
      else begin failures++; $error("FAIL timeout observed=%b expected=%b", timeout_o, e.to); end
    end
  endtask

  // Drive inputs for the next edge, queue the outputs expected after it, then compare.
  task automatic step(input logic [31:0] req, input logic done,
                      input logic [31:0] g, input logic [4:0] idx, input logic to);
    exp_t e;
    req_i = req;
    done_i = done;
    e.gnt = g;
    e.idx = idx;
    e.valid = |g;
    e.to = to;
    sb.push_back(e);
    @(posedge clk_i);
    @(negedge clk_i);
    check_out();
  endtask

  task automatic do_reset();
    #2 rst_ni = 1'b0;
    #1;
    checks += 4;
    assert (gnt_o === 32'h0)
    else begin failures++; $error("FAIL rst_gnt observed=%h expected=0", gnt_o); end
    assert (gnt_idx_o === 5'd0)
    else begin failures++; $error("FAIL rst_idx observed=%0d expected=0", gnt_idx_o); end
    assert (gnt_valid_o === 1'b0)
    else begin failures++; $error("FAIL rst_valid observed=%b expected=0", gnt_valid_o); end
    assert (timeout_o === 1'b0)
    else begin failures++; $error("FAIL rst_timeout observed=%b expected=0", timeout_o); end
    req_i = '0;
    done_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    @(negedge clk_i);
    do_reset();

    // Basic grant, done pulse, next arbitration from ptr=1, then drop.
    step(32'h1, 1'b0, 32'h1, 5'd0, 1'b0);
    step(32'h1, 1'b1, 32'h0, 5'd0, 1'b0);
    step(32'h3, 1'b0, 32'h2, 5'd1, 1'b0);
    step(32'h0, 1'b0, 32'h0, 5'd1, 1'b0);
    step(32'h0, 1'b0, 32'h0, 5'd1, 1'b0);

    // Rotation 0, 2, 31, 0, 2 with one bubble between grants.
    do_reset();
    step(32'h8000_0005, 1'b0, 32'h1,         5'd0,  1'b0);
    step(32'h8000_0005, 1'b1, 32'h0,         5'd0,  1'b0);
    step(32'h8000_0005, 1'b0, 32'h4,         5'd2,  1'b0);
    step(32'h8000_0005, 1'b1, 32'h0,         5'd2,  1'b0);
    step(32'h8000_0005, 1'b0, 32'h8000_0000, 5'd31, 1'b0);
    step(32'h8000_0005, 1'b1, 32'h0,         5'd31, 1'b0);
    step(32'h8000_0005, 1'b0, 32'h1,         5'd0,  1'b0);
    step(32'h8000_0005, 1'b1, 32'h0,         5'd0,  1'b0);
    step(32'h8000_0005, 1'b0, 32'h4,         5'd2,  1'b0);
    step(32'h8000_0005, 1'b1, 32'h0,         5'd2,  1'b0);
    step(32'h0,         1'b0, 32'h0,         5'd2,  1'b0);

    // Timeout after 16 grant cycles, bubble, re-grant, then drop.
    step(32'h10, 1'b0, 32'h10, 5'd4, 1'b0);
    for (int i = 0; i < 15; i++) step(32'h10, 1'b0, 32'h10, 5'd4, 1'b0);
    step(32'h10, 1'b0, 32'h0,  5'd4, 1'b1);
    step(32'h10, 1'b0, 32'h10, 5'd4, 1'b0);
    step(32'h0,  1'b0, 32'h0,  5'd4, 1'b0);
    step(32'h0,  1'b0, 32'h0,  5'd4, 1'b0);

    // Requester 7 drops; ptr=8 shown by 8 beating 7 next.
    step(32'h80,  1'b0, 32'h80,  5'd7, 1'b0);
    step(32'h80,  1'b0, 32'h80,  5'd7, 1'b0);
    step(32'h0,   1'b0, 32'h0,   5'd7, 1'b0);
    step(32'h180, 1'b0, 32'h100, 5'd8, 1'b0);
    step(32'h180, 1'b1, 32'h0,   5'd8, 1'b0);
    step(32'h0,   1'b0, 32'h0,   5'd8, 1'b0);

    // Wrap after index 31, then 0, 30, 31.
    step(32'h8000_0000, 1'b0, 32'h8000_0000, 5'd31, 1'b0);
    step(32'hC000_0001, 1'b1, 32'h0,         5'd31, 1'b0);
    step(32'hC000_0001, 1'b0, 32'h1,         5'd0,  1'b0);
    step(32'hC000_0001, 1'b1, 32'h0,         5'd0,  1'b0);
    step(32'hC000_0001, 1'b0, 32'h4000_0000, 5'd30, 1'b0);
    step(32'hC000_0001, 1'b1, 32'h0,         5'd30, 1'b0);
    step(32'hC000_0001, 1'b0, 32'h8000_0000, 5'd31, 1'b0);
    step(32'hC000_0001, 1'b1, 32'h0,         5'd31, 1'b0);
    step(32'h0,         1'b0, 32'h0,         5'd31, 1'b0);

    // Reset in GRANT with ptr=3; afterwards ptr=0 picks 1 over 3.
    step(32'h4, 1'b0, 32'h4, 5'd2, 1'b0);
    step(32'h4, 1'b1, 32'h0, 5'd2, 1'b0);
    step(32'h4, 1'b0, 32'h4, 5'd2, 1'b0);
    do_reset();
    step(32'hA, 1'b0, 32'h2, 5'd1, 1'b0);
    step(32'h0, 1'b0, 32'h0, 5'd1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_32.md
Name: rr_arbiter_32

Overview:
Round-robin arbiter sharing one resource among up to 32 requesters. Arbitration uses a rotating-mask priority encode: the lowest-index request at or above the pointer wins. If no request is at or above the pointer, it wraps to the lowest-index request overall. The grant is registered and held until the winner signals completion, drops its request, or hits a hold-time limit. The block sits in front of any shared datapath resource (bus port, execution unit) that one requester owns at a time.

Parameters:
N, 32, number of requesters; legal range 2..32.
IDX_W, $clog2(N), width of the grant index and of the pointer; derived, not overridden.
MAX_HOLD, 16, maximum number of GRANT cycles before a forced release; 0 disables the timeout.

Ports:
clk_i  input  1  clock; all state updates on its rising edge.
rst_ni  input  1  asynchronous active-low reset.
req_i  input  N  request vector; bit k high means requester k wants the resource.
done_i  input  1  current grantee finished; sampled only in GRANT.
gnt_o  output  N  one-hot grant vector; all zero when nothing is granted.
gnt_idx_o  output  IDX_W  binary index of the grantee; holds its last value when gnt_valid_o=0.
gnt_valid_o  output  1  high exactly when gnt_o is nonzero.
timeout_o  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- Reset (asynchronous, immediate, no clock needed) puts the block in this state:
  - state=IDLE, ptr=0, hold_cnt=0.
  - gnt_o=0, gnt_idx_o=0, gnt_valid_o=0, timeout_o=0.
- Arbitration function, combinational on the current req_i and ptr:
  - masked = req_i & (bits >= ptr).
  - winner = lowest set bit of masked if masked≠0, else lowest set bit of req_i.
- All outputs are registered. Latency from request to grant is 1 cycle: req_i seen at edge t gives gnt_o valid after edge t+1.
- States:
  - IDLE: if req_i≠0, load gnt_o=onehot(winner), gnt_idx_o=winner, gnt_valid_o=1, hold_cnt=0, then go to GRANT. Otherwise stay in IDLE.
  - GRANT: outputs are held stable and hold_cnt increments every cycle. Release occurs on the first cycle where any of these is true:
    - (a) done_i=1;
    - (b) req_i[gnt_idx_o]=0;
    - (c) MAX_HOLD≠0 and hold_cnt==MAX_HOLD-1.
  - On release: gnt_o=0, gnt_valid_o=0, ptr=(gnt_idx_o+1) mod N, go to RELEASE.
  - On release by (c) only, timeout_o=1 for that one registered cycle.
  - RELEASE: a one-cycle bubble with no grant. If req_i≠0, arbitrate using the updated ptr and enter GRANT as IDLE does; otherwise go to IDLE.
- Minimum gap between two grants is 1 cycle with gnt_valid_o=0.
- Simultaneous release conditions: if (a) or (b) occurs in the same cycle as (c), timeout_o stays 0.
- Pointer wrap: a grant to index N-1 sets ptr=0.
- Requests that appear or drop while another requester holds the grant have no effect until the next arbitration.
- gnt_o must always be one-hot or zero. The bench asserts this every cycle.

Optional Feature:
RR_ARB_LOCK_EN
- When defined:
  - Adds port lock_i (input, 1), owned by the current grantee.
  - In GRANT with lock_i=1, hold_cnt is frozen and release condition (c) is ignored.
  - A release by (a) while lock_i=1 leaves ptr=gnt_idx_o, so a still-requesting grantee wins again after the RELEASE bubble.
  - A release by (b) always advances ptr.
- When undefined: no lock_i port, and behaviour is exactly as in Behaviour.

Test Plan:
1. Basic grant: reset, then req_i=0x0000_0001 at edge t.
   -> After t+1: gnt_o=0x1, gnt_idx_o=0, gnt_valid_o=1.
   -> One-cycle done_i pulse: gnt_o=0 on the next cycle, and the next grant uses ptr=1.
2. Rotation: req_i=0x8000_0005 held, done_i asserted on every grant's first cycle.
   -> Grant index sequence 0, 2, 31, 0, 2, each separated by one bubble cycle.
3. Timeout: MAX_HOLD=16, req_i=0x0000_0010 held, done_i=0.
   -> gnt_o=0x10 for 16 cycles, timeout_o=1 on the release cycle.
   -> One bubble cycle, then re-grant to index 4.
4. Requester drop: grant to index 7, then req_i[7] deasserts.
   -> gnt_o=0 on the next cycle, timeout_o=0, ptr=8.
5. Wrap and fairness: after a grant to index 31, release with req_i=0xC000_0001.
   -> Next grant is index 0, then 30, then 31.
6. Reset mid-GRANT: drop rst_ni between clock edges.
   -> All outputs are 0 immediately, with no clock edge.
   -> After reset release with req_i=0x2, the grant goes to index 1 (ptr was cleared to 0).
